// File: rtl/sel_pkg.sv
// Shared types and constants for the case-select arbiter/checker.
// Mode encoding and sticky error flag bit positions.
package sel_pkg;

  typedef enum logic [1:0] {
    SEL_PRIORITY = 2'd0,
    SEL_UNIQUE   = 2'd1,
    SEL_RR       = 2'd2
  } sel_mode_e;

  localparam int ERR_MULTI = 0;
  localparam int ERR_NOHIT = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (clr)                    r_cnt <= '0;
    else if (inc && (r_cnt != '1))   r_cnt <= r_cnt + W'(1);
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/sel_arb_check.sv
// Case-item selector: priority / unique-checked / round-robin grant from a
// request vector, one-entry registered output with valid/ready handshake.
module sel_arb_check
  import sel_pkg::*;
#(
  parameter int        N     = 4,
  parameter sel_mode_e MODE  = SEL_PRIORITY,
  parameter int        CNT_W = 8,
  localparam int       IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [N-1:0]     gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [CNT_W-1:0] multi_cnt,
  output logic [CNT_W-1:0] nohit_cnt,
  output logic [1:0]       err_flags,
  input  logic             clr_cnt
);

  logic [N-1:0]  r_gnt;
  logic [IW-1:0] r_idx;
  logic          r_vld;
  logic [IW-1:0] r_ptr;
  logic [1:0]    r_err;

  logic          w_accept;
  logic          w_hit;
  logic [IW-1:0] w_sel_idx;
  logic [N-1:0]  w_sel_gnt;
  logic [IW-1:0] w_ptr_nxt;
  logic          w_multi;
  logic          w_nohit;
  logic          w_cnt_multi;
  logic          w_cnt_nohit;

  assign req_ready = !r_vld || gnt_ready;
  assign w_accept  = req_valid && req_ready;

  // Selection: scan from the top down so the lowest qualifying position
  // is the last one written and therefore wins.
  always_comb begin
    int j;
    j         = 0;
    w_hit     = 1'b0;
    w_sel_idx = '0;
    if (MODE == SEL_RR) begin
      for (int off = N - 1; off >= 0; off--) begin
        j = int'(r_ptr) + off;
        if (j >= N) j = j - N;
        if (req[j]) begin
          w_hit     = 1'b1;
          w_sel_idx = IW'(j);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          w_hit     = 1'b1;
          w_sel_idx = IW'(i);
        end
      end
    end
  end

  assign w_sel_gnt   = w_hit ? (N'(1) << w_sel_idx) : '0;
  assign w_ptr_nxt   = (w_sel_idx == IW'(N - 1)) ? '0 : w_sel_idx + IW'(1);
  assign w_multi     = |(req & (req - N'(1)));
  assign w_nohit     = ~|req;
  assign w_cnt_multi = w_accept && (MODE == SEL_UNIQUE) && w_multi;
  assign w_cnt_nohit = w_accept && w_nohit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt <= '0;
      r_idx <= '0;
      r_vld <= 1'b0;
    end else if (w_accept) begin
      r_gnt <= w_sel_gnt;
      r_idx <= w_sel_idx;
      r_vld <= 1'b1;
    end else if (gnt_ready) begin
      r_vld <= 1'b0;
    end
  end

  // Pointer only advances past a real grant; an empty request leaves it put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ptr <= '0;
    else if (w_accept && w_hit && (MODE == SEL_RR))
      r_ptr <= w_ptr_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else if (clr_cnt) begin
      r_err <= '0;
    end else begin
      if (w_cnt_multi) r_err[ERR_MULTI] <= 1'b1;
      if (w_cnt_nohit) r_err[ERR_NOHIT] <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_multi_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_cnt_multi),
    .clr (clr_cnt),
    .cnt (multi_cnt)
  );

  sat_counter #(.W(CNT_W)) u_nohit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_cnt_nohit),
    .clr (clr_cnt),
    .cnt (nohit_cnt)
  );

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_vld;
  assign err_flags = r_err;

endmodule

// File: tb/tb_sel_arb_check.sv
// Three instances (priority, unique w/ 2-bit counters, round-robin) share one
// stimulus stream; expected grants go to per-instance queues checked by a monitor.
module tb_sel_arb_check;
  import sel_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       req_valid;
  logic       gnt_ready;
  logic       clr_cnt;

  logic       p_rdy, u_rdy, r_rdy;
  logic [3:0] p_gnt, u_gnt, r_gnt;
  logic [1:0] p_idx, u_idx, r_idx;
  logic       p_gv, u_gv, r_gv;
  logic [7:0] p_mc, p_nc, r_mc, r_nc;
  logic [1:0] u_mc, u_nc;
  logic [1:0] p_ef, u_ef, r_ef;

  int errs = 0;
  int checks = 0;
  logic [3:0] qp[$], qu[$], qr[$];

  always #5 clk = ~clk;

  sel_arb_check #(.N(4), .MODE(SEL_PRIORITY), .CNT_W(8)) u_pri (
    .clk(clk), .rst(rst), .req(req), .req_valid(req_valid), .req_ready(p_rdy),
    .gnt(p_gnt), .gnt_idx(p_idx), .gnt_valid(p_gv), .gnt_ready(gnt_ready),
    .multi_cnt(p_mc), .nohit_cnt(p_nc), .err_flags(p_ef), .clr_cnt(clr_cnt));

  sel_arb_check #(.N(4), .MODE(SEL_UNIQUE), .CNT_W(2)) u_uni (
    .clk(clk), .rst(rst), .req(req), .req_valid(req_valid), .req_ready(u_rdy),
    .gnt(u_gnt), .gnt_idx(u_idx), .gnt_valid(u_gv), .gnt_ready(gnt_ready),
    .multi_cnt(u_mc), .nohit_cnt(u_nc), .err_flags(u_ef), .clr_cnt(clr_cnt));

  sel_arb_check #(.N(4), .MODE(SEL_RR), .CNT_W(8)) u_rr (
    .clk(clk), .rst(rst), .req(req), .req_valid(req_valid), .req_ready(r_rdy),
    .gnt(r_gnt), .gnt_idx(r_idx), .gnt_valid(r_gv), .gnt_ready(gnt_ready),
    .multi_cnt(r_mc), .nohit_cnt(r_nc), .err_flags(r_ef), .clr_cnt(clr_cnt));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_idx(input logic [3:0] g);
    int k;
    k = 0;
    for (int i = 3; i >= 0; i--) if (g[i]) k = i;
    return k;
  endfunction

  task automatic beat(input string nm, input logic [3:0] exp, input logic [3:0] g,
                      input logic [1:0] idx);
    chk({nm, "_gnt"}, int'(g), int'(exp));
    chk({nm, "_idx"}, int'(idx), exp_idx(exp));
  endtask

  // Monitor: a beat leaves the DUT on any edge where valid && ready.
  always @(negedge clk) begin
    if (!rst && gnt_ready) begin
      if (p_gv) begin
        if (qp.size() == 0) chk("pri_unexpected_beat", 1, 0);
        else beat("pri", qp.pop_front(), p_gnt, p_idx);
      end
      if (u_gv) begin
        if (qu.size() == 0) chk("uni_unexpected_beat", 1, 0);
        else beat("uni", qu.pop_front(), u_gnt, u_idx);
      end
      if (r_gv) begin
        if (qr.size() == 0) chk("rr_unexpected_beat", 1, 0);
        else beat("rr", qr.pop_front(), r_gnt, r_idx);
      end
    end
  end

  task automatic send(input logic [3:0] r, input logic [3:0] ep, input logic [3:0] eu,
                      input logic [3:0] er, input bit push, input bit clr);
    int n;
    n = 0;
    req = r; req_valid = 1'b1; clr_cnt = clr;
    @(negedge clk);
    while (!p_rdy && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!p_rdy) chk("send_timeout", 0, 1);
    else if (push) begin
      qp.push_back(ep); qu.push_back(eu); qr.push_back(er);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; clr_cnt = 1'b0; req = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_valid = 1'b0; gnt_ready = 1'b1; clr_cnt = 1'b0;
    idle(2);
    chk("rst_gv", int'(p_gv | u_gv | r_gv), 0);
    chk("rst_gnt", int'(p_gnt | u_gnt | r_gnt), 0);
    chk("rst_cnt", int'(p_mc | p_nc | u_mc | u_nc | r_nc), 0);
    chk("rst_flags", int'(p_ef | u_ef | r_ef), 0);
    rst = 1'b0; #1;
    chk("rst_ready", int'(p_rdy & u_rdy & r_rdy), 1);

    // 1111 x5: RR walks 0,1,2,3,0; unique counter saturates at 3
    send(4'b1111, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    send(4'b1111, 4'b0001, 4'b0001, 4'b0010, 1, 0);
    send(4'b1111, 4'b0001, 4'b0001, 4'b0100, 1, 0);
    send(4'b1111, 4'b0001, 4'b0001, 4'b1000, 1, 0);
    send(4'b1111, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    chk("uni_multi_sat", int'(u_mc), 3);
    chk("uni_flags_multi", int'(u_ef), 1);
    chk("pri_multi_nocount", int'(p_mc), 0);
    chk("rr_multi_nocount", int'(r_mc), 0);

    // sixth multi-hit together with clear: clear wins
    send(4'b1010, 4'b0010, 4'b0010, 4'b0010, 1, 1);
    chk("uni_clr_multi", int'(u_mc), 0);
    chk("uni_clr_flags", int'(u_ef), 0);

    send(4'b0110, 4'b0010, 4'b0010, 4'b0100, 1, 0);
    send(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    chk("uni_multi", int'(u_mc), 1);
    chk("uni_nohit", int'(u_nc), 1);
    chk("uni_flags", int'(u_ef), 3);
    chk("pri_flags", int'(p_ef), 2);
    chk("pri_nohit", int'(p_nc), 1);
    chk("rr_nohit", int'(r_nc), 1);

    // RR pointer held at 3 across the empty request, so 0001 wraps
    send(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    send(4'b0100, 4'b0100, 4'b0100, 4'b0100, 1, 0);

    // backpressure with an empty request waiting: nothing may be counted
    gnt_ready = 1'b0; req = 4'b0000; req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", int'(p_rdy), 0);
      chk("bp_gnt_held", int'(p_gnt), 4'b0100);
      chk("bp_gv_held", int'(p_gv), 1);
      chk("bp_nohit_held", int'(p_nc), 1);
      @(posedge clk); #1;
    end
    gnt_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_back", int'(p_rdy), 1);
    qp.push_back(4'b0000); qu.push_back(4'b0000); qr.push_back(4'b0000);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_nohit_after", int'(p_nc), 2);
    chk("rr_nohit_after", int'(r_nc), 2);

    // reset in the middle of a stalled beat
    idle(2);
    gnt_ready = 1'b0;
    send(4'b0011, 4'b0001, 4'b0001, 4'b0001, 0, 0);
    chk("mid_gv", int'(p_gv & r_gv), 1);
    chk("mid_uni_multi", int'(u_mc), 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_gv", int'(p_gv | u_gv | r_gv), 0);
    chk("mid_rst_cnt", int'(p_nc | u_mc | u_nc | r_nc), 0);
    chk("mid_rst_flags", int'(p_ef | u_ef | r_ef), 0);
    @(posedge clk); #1;
    rst = 1'b0; gnt_ready = 1'b1;
    // RR pointer back at 0 after reset
    send(4'b1111, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    idle(3);
    chk("queues_drained", qp.size() + qu.size() + qr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
